// File: rtl/vending_ctrl_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vending_ctrl_param_pkg
//  Description : Key-code constants and FSM state encoding shared by the
//                vending controller files.
//  Revision    : 1.0 - initial release
// ============================================================================
package vending_ctrl_param_pkg;

    localparam logic [3:0] c_key_coin_a = 4'hA;
    localparam logic [3:0] c_key_coin_b = 4'hB;
    localparam logic [3:0] c_key_cancel = 4'hC;
    localparam logic [3:0] c_key_vend   = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vending_ctrl_param_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : vending_ctrl_param_bin2bcd
//  Description : Combinational shift-and-add-3 binary to packed BCD converter.
//                The caller registers the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_ctrl_param_bin2bcd #(
    parameter int BIN_W = 8,
    parameter int N_DIG = 3
) (
    input  logic [BIN_W-1:0]   i_bin,
    output logic [4*N_DIG-1:0] o_bcd
);

    logic [4*N_DIG+BIN_W-1:0] w_scratch;

    // Double-dabble: correct each digit >= 5 before every left shift
    always_comb begin
        w_scratch = '0;
        w_scratch[BIN_W-1:0] = i_bin;
        for (int i = 0; i < BIN_W; i++) begin
            for (int d = 0; d < N_DIG; d++) begin
                if (w_scratch[BIN_W+4*d +: 4] >= 4'd5) begin
                    w_scratch[BIN_W+4*d +: 4] = w_scratch[BIN_W+4*d +: 4] + 4'd3;
                end
            end
            w_scratch = w_scratch << 1;
        end
    end

    assign o_bcd = w_scratch[BIN_W +: 4*N_DIG];

endmodule
`default_nettype wire

// File: rtl/vending_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : vending_ctrl_param
//  Description : Parametrised vending controller. Accumulates coin credit,
//                latches a product selection, vends against a price table and
//                pays change out one COIN_UNIT at a time. All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_ctrl_param
    import vending_ctrl_param_pkg::*;
#(
    parameter int                       N_PROD      = 4,
    parameter int                       CREDIT_W    = 8,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE_TABLE = 32'h4B_32_28_19,
    parameter int                       COIN_A      = 10,
    parameter int                       COIN_B      = 25,
    parameter int                       COIN_UNIT   = 5,
    parameter int                       CHANGE_GAP  = 4,
    parameter int                       TIMEOUT_CYC = 1000,
    parameter int                       N_DIG       = 3,
    localparam int                      SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [3:0]         key_code,
    output logic [4*N_DIG-1:0] credit_bcd,
    output logic               sel_valid,
    output logic [SEL_W-1:0]   sel_id,
    output logic               dispense,
    output logic               change_pulse,
    output logic               reject_coin,
    output logic               err,
    output logic               busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(CHANGE_GAP);

    localparam logic [CREDIT_W:0]   c_credit_max = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   c_coin_a     = (CREDIT_W+1)'(COIN_A);
    localparam logic [CREDIT_W:0]   c_coin_b     = (CREDIT_W+1)'(COIN_B);
    localparam logic [CREDIT_W-1:0] c_unit       = CREDIT_W'(COIN_UNIT);

    state_t              r_state, w_state_nx;
    logic [CREDIT_W-1:0] r_credit, w_credit_nx;
    logic                r_sel_valid, w_sel_valid_nx;
    logic [SEL_W-1:0]    r_sel_id, w_sel_id_nx;
    logic [TMR_W-1:0]    r_timer, w_timer_nx;
    logic [GAP_W-1:0]    r_gap, w_gap_nx;
    logic                r_dispense, w_dispense_nx;
    logic                r_change, w_change_nx;
    logic                r_reject, w_reject_nx;
    logic                r_err, w_err_nx;
    logic                r_busy;
    logic [4*N_DIG-1:0]  r_bcd, w_bcd;

    logic [CREDIT_W-1:0] w_price_tab [N_PROD];
    logic [CREDIT_W-1:0] w_price, w_remain;
    logic [CREDIT_W:0]   w_sum;
    logic                w_is_sel, w_is_coin, w_is_cancel, w_is_vend, w_ovf, w_timeout;

    // Unpack the flattened price table into one entry per product
    for (genvar gi = 0; gi < N_PROD; gi++) begin : g_price
        assign w_price_tab[gi] = PRICE_TABLE[gi*CREDIT_W +: CREDIT_W];
    end

    assign w_price     = w_price_tab[r_sel_id];
    assign w_remain    = r_credit - w_price;
    assign w_is_sel    = key_valid && (key_code < 4'(N_PROD));
    assign w_is_coin   = key_valid && (key_code == c_key_coin_a || key_code == c_key_coin_b);
    assign w_is_cancel = key_valid && (key_code == c_key_cancel);
    assign w_is_vend   = key_valid && (key_code == c_key_vend);
    // One extra bit so an overflowing coin is detected rather than wrapped
    assign w_sum       = {1'b0, r_credit} + ((key_code == c_key_coin_a) ? c_coin_a : c_coin_b);
    assign w_ovf       = (w_sum > c_credit_max);
    assign w_timeout   = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Next-state, datapath and pulse decisions
    always_comb begin
        w_state_nx     = r_state;
        w_credit_nx    = r_credit;
        w_sel_valid_nx = r_sel_valid;
        w_sel_id_nx    = r_sel_id;
        w_timer_nx     = r_timer;
        w_gap_nx       = r_gap;
        w_dispense_nx  = 1'b0;
        w_change_nx    = 1'b0;
        w_reject_nx    = 1'b0;
        w_err_nx       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_nx = '0;
                if (w_is_coin) begin
                    if (w_ovf) w_reject_nx = 1'b1;
                    else       w_credit_nx = w_sum[CREDIT_W-1:0];
                    w_state_nx = ST_CREDIT;
                end else if (w_is_sel) begin
                    w_sel_valid_nx = 1'b1;
                    w_sel_id_nx    = key_code[SEL_W-1:0];
                    w_state_nx     = ST_CREDIT;
                end else if (w_is_vend) begin
                    w_err_nx = 1'b1;
                end
            end
            ST_CREDIT: begin
                if (key_valid) begin
                    // Any key, even an ignored one, restarts the idle timer
                    w_timer_nx = '0;
                    if (w_is_coin) begin
                        if (w_ovf) w_reject_nx = 1'b1;
                        else       w_credit_nx = w_sum[CREDIT_W-1:0];
                    end else if (w_is_sel) begin
                        w_sel_valid_nx = 1'b1;
                        w_sel_id_nx    = key_code[SEL_W-1:0];
                    end else if (w_is_vend) begin
                        if (!r_sel_valid || r_credit < w_price) begin
                            w_err_nx = 1'b1;
                        end else begin
                            w_dispense_nx = 1'b1;
                            w_state_nx    = ST_VEND;
                        end
                    end else if (w_is_cancel) begin
                        w_sel_valid_nx = 1'b0;
                        w_gap_nx       = '0;
                        w_state_nx     = ST_CHANGE;
                    end
                end else if (w_timeout) begin
                    w_sel_valid_nx = 1'b0;
                    w_gap_nx       = '0;
                    w_state_nx     = ST_CHANGE;
                end else begin
                    w_timer_nx = r_timer + TMR_W'(1);
                end
            end
            ST_VEND: begin
                w_credit_nx    = w_remain;
                w_sel_valid_nx = 1'b0;
                w_gap_nx       = '0;
                w_state_nx     = (w_remain >= c_unit) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (r_credit < c_unit) begin
                    w_credit_nx = '0;
                    w_state_nx  = ST_IDLE;
                end else if (r_gap == '0) begin
                    w_change_nx = 1'b1;
                    w_credit_nx = r_credit - c_unit;
                    w_gap_nx    = GAP_W'(CHANGE_GAP - 1);
                end else begin
                    w_gap_nx = r_gap - GAP_W'(1);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_credit    <= '0;
            r_sel_valid <= 1'b0;
            r_sel_id    <= '0;
            r_timer     <= '0;
            r_gap       <= '0;
            r_dispense  <= 1'b0;
            r_change    <= 1'b0;
            r_reject    <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_bcd       <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_credit    <= w_credit_nx;
            r_sel_valid <= w_sel_valid_nx;
            r_sel_id    <= w_sel_id_nx;
            r_timer     <= w_timer_nx;
            r_gap       <= w_gap_nx;
            r_dispense  <= w_dispense_nx;
            r_change    <= w_change_nx;
            r_reject    <= w_reject_nx;
            r_err       <= w_err_nx;
            r_busy      <= (w_state_nx == ST_VEND) || (w_state_nx == ST_CHANGE);
            r_bcd       <= w_bcd;
        end
    end

    vending_ctrl_param_bin2bcd #(
        .BIN_W (CREDIT_W),
        .N_DIG (N_DIG)
    ) u_bin2bcd (
        .i_bin (r_credit),
        .o_bcd (w_bcd)
    );

    assign credit_bcd   = r_bcd;
    assign sel_valid    = r_sel_valid;
    assign sel_id       = r_sel_id;
    assign dispense     = r_dispense;
    assign change_pulse = r_change;
    assign reject_coin  = r_reject;
    assign err          = r_err;
    assign busy         = r_busy;

endmodule
`default_nettype wire
